branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, meaning the width of fetch addresses.
REQ-002 SHALL have parameter ENTRIES, default 64, meaning the number of BTB/counter entries (power of two, 4..1024).
REQ-003 SHALL have parameter CTR_BITS, default 2, meaning the width of the saturating counter (1..4).
REQ-004 SHALL have parameter MODE, default 0, meaning the index function (0 = bimodal, 1 = gshare).
REQ-005 SHALL have parameter RAS_DEPTH, default 8, meaning the number of return-stack entries (power of two).
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous active-low reset.
REQ-009 bp_enable  in  1  high to allow taken predictions.
REQ-010 if_valid / if_stall / if_pc  in  1/1/PC_WIDTH  fetch query, hold request, fetch PC.
REQ-011 pred_taken / pred_target / pred_ghr  out  1/PC_WIDTH/log2(ENTRIES)  prediction, target, history snapshot.
REQ-012 upd_valid / upd_pc / upd_target / upd_taken  in  1/PC_WIDTH/PC_WIDTH/1  resolved control transfer from EX.
REQ-013 upd_type / upd_ghr  in  2/log2(ENTRIES)  type (0 = branch, 1 = jump, 2 = call, 3 = return) and the pred_ghr value carried with the instruction.

Function
REQ-014 SHALL produce outputs registered one cycle after an if_valid query, so they align with synchronous-read instruction memory.
REQ-015 SHALL hold all outputs unchanged while if_stall=1.
REQ-016 SHALL form the index as if_pc[IDX+1:2] when MODE=0 and as that value XOR GHR when MODE=1; the tag is the remaining PC bits above bit IDX+1.
REQ-017 SHALL store per entry: valid, tag, target[PC_WIDTH-1:2], type and counter.
REQ-018 SHALL set pred_taken=1 only on tag hit with bp_enable=1 and either (type is branch with counter MSB=1) or (type is not branch).
REQ-019 SHALL drive pred_target={stored target,2'b00} on hit, and if_pc+4 otherwise.
REQ-020 SHALL, on update, index with upd_ghr (MODE=1) or upd_pc (MODE=0).
REQ-021 SHALL, on an update hit, saturate the counter up when taken and down when not taken (no wrap), and rewrite the target and type.
REQ-022 SHALL, on an update miss with upd_taken=1, allocate the entry: branches get counter 2^(CTR_BITS-1), other types get all ones.
REQ-023 SHALL NOT allocate on an update miss with upd_taken=0.
REQ-024 SHALL shift upd_taken into GHR on every branch-type update.
REQ-025 SHALL read pre-update state (read-before-write) when a query and an update address the same index in the same cycle.
REQ-026 SHALL still train the tables when bp_enable=0.

Reset
REQ-027 SHALL, on rst=0, clear every valid bit, GHR, the RAS pointer and RAS count, and drive pred_taken=0, pred_target=0 and pred_ghr=0 from the next edge, including mid-operation.
REQ-028 SHALL take effect regardless of if_stall.

Configuration
REQ-029 SHALL compile the return-address stack only when macro BRANCH_PREDICTOR_RAS_EN is defined.
REQ-030 SHALL, with the macro defined: push upd_pc+4 on a resolved call; pop on a resolved return; predict a return hit with the RAS top as target.
REQ-031 SHALL, with the macro defined: overwrite the oldest RAS entry on overflow (pointer wraps); ignore a pop when empty; use the BTB target when the RAS is empty.
REQ-032 SHALL, without the macro, predict returns from the BTB target and instantiate no RAS storage.

Structure
REQ-033 SHALL place the upd_type encoding constants and the counter helper function in shared package bp_pkg.
REQ-034 SHALL implement the RAS as sub-module bp_ras.

Verification
REQ-035 Reset then query 0x4000_0010 -> pred_taken=0, pred_target=0x4000_0014.
REQ-036 Branch updates at 0x4000_0020 to 0x4000_0100, sequence taken, taken, not-taken (CTR_BITS=2) -> after the first, predicts taken to 0x4000_0100; after the second, counter reads 3; after the third, counter reads 2 and predicts taken.
REQ-037 Jump allocated at 0x4000_0040, then bp_enable=0 -> pred_taken=0; bp_enable=1 -> predicts taken.
REQ-038 Query and update to the same index in one cycle -> prediction reflects old state; the next query reflects the new state.
REQ-039 MODE=1, two branches aliasing under different GHR values -> independent counters.
REQ-040 Macro on, RAS_DEPTH=8, nine calls then nine returns -> the first eight returns predict in LIFO order and the ninth uses the BTB target.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: definitions shared by the branch predictor and its return stack.
//   br_type_e : encoding of the resolved control-transfer type (upd_type)
//   ctr_sat   : saturating up/down step for counters up to 4 bits wide
package bp_pkg;

    typedef enum logic [1:0] {
        BR_BRANCH = 2'd0,
        BR_JUMP   = 2'd1,
        BR_CALL   = 2'd2,
        BR_RETURN = 2'd3
    } br_type_e;

    // Counter steps toward ctr_max or toward zero and sticks at either end.
    function automatic logic [3:0] ctr_sat(input logic [3:0] ctr,
                                           input logic [3:0] ctr_max,
                                           input logic       up);
        logic [3:0] res;
        if (up) begin
            if (ctr >= ctr_max) begin
                res = ctr_max;
            end else begin
                res = ctr + 4'd1;
            end
        end else begin
            if (ctr == 4'd0) begin
                res = 4'd0;
            end else begin
                res = ctr - 4'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack.
//   clk, rst (sync, active-low) : clock and reset (clears pointer and count)
//   push, push_addr             : store a return address at the top
//   pop                         : drop the top entry; ignored when empty
//   top, empty                  : current top entry and empty flag
// On overflow the pointer wraps and the oldest entry is overwritten; the
// count saturates at DEPTH so later pops stop after DEPTH entries.
module bp_ras
    import bp_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_addr,
    output logic [PC_WIDTH-1:0] top,
    output logic                empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PC_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]    ptr_r;
    logic [PTR_W:0]      cnt_r;

    // ptr_r points at the next free slot, so the top lives one below it.
    assign top   = mem_r[ptr_r - PTR_ONE];
    assign empty = (cnt_r == {(PTR_W + 1){1'b0}});

    // Stack pointer and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= {PTR_W{1'b0}};
            cnt_r <= {(PTR_W + 1){1'b0}};
        end else if (push) begin
            ptr_r <= ptr_r + PTR_ONE;
            cnt_r <= (cnt_r == CNT_FULL) ? CNT_FULL : cnt_r + CNT_ONE;
        end else if (pop && !empty) begin
            ptr_r <= ptr_r - PTR_ONE;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            ptr_r <= ptr_r;
            cnt_r <= cnt_r;
        end
    end

    // Return-address storage; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_r[ptr_r] <= push_addr;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with per-entry saturating counters, bimodal or gshare
// indexing, and an optional return-address stack (macro BRANCH_PREDICTOR_RAS_EN).
//   clk, rst (sync, active-low)        : clock and reset
//   bp_enable                          : allow taken predictions
//   if_valid, if_stall, if_pc          : fetch query, output hold, fetch PC
//   pred_taken, pred_target, pred_ghr  : registered prediction + history snapshot
//   upd_valid/pc/target/taken/type/ghr : resolved control transfer from EX
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int MODE      = 0,
    parameter int RAS_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bp_enable,
    input  logic                        if_valid,
    input  logic                        if_stall,
    input  logic [PC_WIDTH-1:0]         if_pc,
    output logic                        pred_taken,
    output logic [PC_WIDTH-1:0]         pred_target,
    output logic [$clog2(ENTRIES)-1:0]  pred_ghr,
    input  logic                        upd_valid,
    input  logic [PC_WIDTH-1:0]         upd_pc,
    input  logic [PC_WIDTH-1:0]         upd_target,
    input  logic                        upd_taken,
    input  logic [1:0]                  upd_type,
    input  logic [$clog2(ENTRIES)-1:0]  upd_ghr
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;
    localparam int TGT_W = PC_WIDTH - 2;
    localparam logic [3:0]          CTR_MAX  = 4'((1 << CTR_BITS) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [PC_WIDTH-1:0] PC_STEP  = {{(PC_WIDTH - 3){1'b0}}, 3'd4};

    logic                valid_r [ENTRIES];
    logic [TAG_W-1:0]    tag_r   [ENTRIES];
    logic [TGT_W-1:0]    tgt_r   [ENTRIES];
    br_type_e            type_r  [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r   [ENTRIES];
    logic [IDX-1:0]      ghr_r;

    logic [IDX-1:0]      q_idx_s, u_idx_s;
    logic                q_hit_s, u_hit_s, q_taken_s;
    logic [PC_WIDTH-1:0] q_target_s;
    br_type_e            u_type_s;
    logic [3:0]          u_ctr_ext_s;
    logic [CTR_BITS-1:0] u_ctr_s;
    logic                unused_s;

    assign unused_s = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]};
    assign u_type_s = br_type_e'(upd_type);

    // gshare folds history into the index; bimodal uses PC bits alone.
    assign q_idx_s = if_pc[IDX+1:2]  ^ ((MODE == 1) ? ghr_r   : {IDX{1'b0}});
    assign u_idx_s = upd_pc[IDX+1:2] ^ ((MODE == 1) ? upd_ghr : {IDX{1'b0}});
    assign q_hit_s = valid_r[q_idx_s] && (tag_r[q_idx_s] == if_pc[PC_WIDTH-1:IDX+2]);
    assign u_hit_s = valid_r[u_idx_s] && (tag_r[u_idx_s] == upd_pc[PC_WIDTH-1:IDX+2]);

`ifdef BRANCH_PREDICTOR_RAS_EN
    logic [PC_WIDTH-1:0] ras_top_s;
    logic                ras_empty_s;

    bp_ras #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (upd_valid && (u_type_s == BR_CALL)),
        .pop       (upd_valid && (u_type_s == BR_RETURN)),
        .push_addr (upd_pc + PC_STEP),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );
`endif

    // Lookup: array reads are combinational on pre-update state, giving
    // read-before-write when a query and an update share an index.
    always_comb begin
        q_taken_s  = 1'b0;
        q_target_s = if_pc + PC_STEP;
        if (q_hit_s) begin
            q_taken_s  = bp_enable &&
                         ((type_r[q_idx_s] != BR_BRANCH) || ctr_r[q_idx_s][CTR_BITS-1]);
            q_target_s = {tgt_r[q_idx_s], 2'b00};
`ifdef BRANCH_PREDICTOR_RAS_EN
            if ((type_r[q_idx_s] == BR_RETURN) && !ras_empty_s) begin
                q_target_s = ras_top_s;
            end else begin
                q_target_s = {tgt_r[q_idx_s], 2'b00};
            end
`endif
        end else begin
            q_taken_s  = 1'b0;
            q_target_s = if_pc + PC_STEP;
        end
    end

    // Counter value written on update: train a hit, or seed a fresh allocation.
    always_comb begin
        u_ctr_ext_s = ctr_sat(4'(ctr_r[u_idx_s]), CTR_MAX, upd_taken);
        u_ctr_s     = CTR_WEAK;
        if (u_hit_s) begin
            u_ctr_s = u_ctr_ext_s[CTR_BITS-1:0];
        end else if (u_type_s == BR_BRANCH) begin
            u_ctr_s = CTR_WEAK;
        end else begin
            u_ctr_s = {CTR_BITS{1'b1}};
        end
    end

    // Entry valid bits: cleared by reset, set on a taken miss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (upd_valid && !u_hit_s && upd_taken) begin
            valid_r[u_idx_s] <= 1'b1;
        end else begin
            valid_r[u_idx_s] <= valid_r[u_idx_s];
        end
    end

    // Entry payload: rewritten on any hit or on a taken miss (allocation).
    always_ff @(posedge clk) begin
        if (rst && upd_valid && (u_hit_s || upd_taken)) begin
            tag_r[u_idx_s]  <= upd_pc[PC_WIDTH-1:IDX+2];
            tgt_r[u_idx_s]  <= upd_target[PC_WIDTH-1:2];
            type_r[u_idx_s] <= u_type_s;
            ctr_r[u_idx_s]  <= u_ctr_s;
        end
    end

    // Global history shifts in the outcome of every resolved branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr_r <= {IDX{1'b0}};
        end else if (upd_valid && (u_type_s == BR_BRANCH)) begin
            ghr_r <= {ghr_r[IDX-2:0], upd_taken};
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Prediction registers: load on an unstalled query, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_taken  <= 1'b0;
            pred_target <= {PC_WIDTH{1'b0}};
            pred_ghr    <= {IDX{1'b0}};
        end else if (if_valid && !if_stall) begin
            pred_taken  <= q_taken_s;
            pred_target <= q_target_s;
            pred_ghr    <= ghr_r;
        end else begin
            pred_taken  <= pred_taken;
            pred_target <= pred_target;
            pred_ghr    <= pred_ghr;
        end
    end

endmodule
